// File: rtl/fetch_pc_unit.sv
// PC/LR holder and single-instruction fetch stage feeding decode over valid/ready.
// Optional LR return stack enabled by defining FETCH_LR_STACK_EN.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_LR = 16'h0000,
  parameter int unsigned TIMEOUT  = 8,
  parameter int unsigned LR_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc,
  output logic [15:0] lr,
  input  logic [15:0] pcnext,
  input  logic [15:0] lrnext,
  input  logic        lr_push,
  input  logic        lr_pop,
  input  logic        halt,
  output logic        fetch_err,
  output logic        halted
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StReq, StHold, StHalt} state_e;

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [15:0]     pc_q;
  logic [15:0]     instr_q;
  logic            fetch_err_q;
  logic            commit;

  assign commit = (state_q == StHold) && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StReq;
      wait_cnt_q  <= '0;
      pc_q        <= RESET_PC;
      instr_q     <= 16'h0000;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= 1'b0;
      case (state_q)
        StReq: begin
          // Data arriving on the timeout cycle wins over the error.
          if (imem_valid) begin
            instr_q    <= imem_rdata;
            wait_cnt_q <= '0;
            state_q    <= StHold;
          end else if (wait_cnt_q == CntMax) begin
            fetch_err_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (instr_ready) begin
            pc_q    <= pcnext;
            state_q <= halt ? StHalt : StReq;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StHold);
  assign pc          = pc_q;
  assign fetch_err   = fetch_err_q;
  assign halted      = (state_q == StHalt);

`ifdef FETCH_LR_STACK_EN
  localparam int unsigned PtrW = (LR_DEPTH > 1) ? $clog2(LR_DEPTH) : 1;
  localparam int unsigned DepW = $clog2(LR_DEPTH + 1);

  logic [15:0]     stk_q [LR_DEPTH];
  logic [PtrW-1:0] top_q;
  logic [PtrW-1:0] top_nxt;
  logic [PtrW-1:0] top_prv;
  logic [DepW-1:0] depth_q;
  logic [15:0]     unused_lrnext;

  assign unused_lrnext = lrnext;
  assign top_nxt = (top_q == PtrW'(LR_DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_prv = (top_q == '0) ? PtrW'(LR_DEPTH - 1) : top_q - 1'b1;

  // Circular buffer: a push onto a full stack silently drops the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q   <= '0;
      depth_q <= '0;
      for (int i = 0; i < LR_DEPTH; i++) stk_q[i] <= RESET_LR;
    end else if (commit) begin
      if (lr_push && lr_pop) begin
        stk_q[top_q] <= pc_q + 16'd1;
      end else if (lr_push) begin
        stk_q[top_nxt] <= pc_q + 16'd1;
        top_q          <= top_nxt;
        if (depth_q != DepW'(LR_DEPTH)) depth_q <= depth_q + 1'b1;
      end else if (lr_pop && depth_q != '0) begin
        top_q   <= top_prv;
        depth_q <= depth_q - 1'b1;
      end
    end
  end

  assign lr = (depth_q == '0) ? RESET_LR : stk_q[top_q];
`else
  logic [15:0] lr_q;
  logic        unused_stack_ctl;

  assign unused_stack_ctl = lr_push ^ lr_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_q <= RESET_LR;
    end else if (commit) begin
      lr_q <= lrnext;
    end
  end

  assign lr = lr_q;
`endif

endmodule
